ps2_key_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_scan2ascii.sv | 49 ++++
 rtl/ps2_key_decoder.sv | 171 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and event layout for the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT     = 8'h12;
    localparam logic [7:0] PS2_RSHIFT     = 8'h59;
    localparam logic [7:0] PS2_CAPS       = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] ascii;
        logic       rpt;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational scan-code set 2 to ASCII lookup; letters honour shift^caps, other keys shift only.
module ps2_scan2ascii (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [15:0] w_pair;
    logic        w_letter;

    // Table entries are {unshifted, shifted}; zero means unmapped.
    always_comb begin
        w_pair = 16'h0000;
        case (code)
            8'h1C: w_pair = 16'h6141; 8'h32: w_pair = 16'h6242; 8'h21: w_pair = 16'h6343;
            8'h23: w_pair = 16'h6444; 8'h24: w_pair = 16'h6545; 8'h2B: w_pair = 16'h6646;
            8'h34: w_pair = 16'h6747; 8'h33: w_pair = 16'h6848; 8'h43: w_pair = 16'h6949;
            8'h3B: w_pair = 16'h6A4A; 8'h42: w_pair = 16'h6B4B; 8'h4B: w_pair = 16'h6C4C;
            8'h3A: w_pair = 16'h6D4D; 8'h31: w_pair = 16'h6E4E; 8'h44: w_pair = 16'h6F4F;
            8'h4D: w_pair = 16'h7050; 8'h15: w_pair = 16'h7151; 8'h2D: w_pair = 16'h7252;
            8'h1B: w_pair = 16'h7353; 8'h2C: w_pair = 16'h7454; 8'h3C: w_pair = 16'h7555;
            8'h2A: w_pair = 16'h7656; 8'h1D: w_pair = 16'h7757; 8'h22: w_pair = 16'h7858;
            8'h35: w_pair = 16'h7959; 8'h1A: w_pair = 16'h7A5A;
            8'h45: w_pair = 16'h3029; 8'h16: w_pair = 16'h3121; 8'h1E: w_pair = 16'h3240;
            8'h26: w_pair = 16'h3323; 8'h25: w_pair = 16'h3424; 8'h2E: w_pair = 16'h3525;
            8'h36: w_pair = 16'h365E; 8'h3D: w_pair = 16'h3726; 8'h3E: w_pair = 16'h382A;
            8'h46: w_pair = 16'h3928;
            8'h0E: w_pair = 16'h607E; 8'h4E: w_pair = 16'h2D5F; 8'h55: w_pair = 16'h3D2B;
            8'h54: w_pair = 16'h5B7B; 8'h5B: w_pair = 16'h5D7D; 8'h5D: w_pair = 16'h5C7C;
            8'h4C: w_pair = 16'h3B3A; 8'h52: w_pair = 16'h2722; 8'h41: w_pair = 16'h2C3C;
            8'h49: w_pair = 16'h2E3E; 8'h4A: w_pair = 16'h2F3F;
            8'h29: w_pair = 16'h2020; 8'h5A: w_pair = 16'h0D0D; 8'h66: w_pair = 16'h0808;
            default: w_pair = 16'h0000;
        endcase
    end

    assign w_letter = (w_pair[15:8] >= 8'h61) && (w_pair[15:8] <= 8'h7A);

    // Letters flip case on shift^caps; everything else on shift alone.
    always_comb begin
        if (w_letter) begin
            ascii = (shift ^ caps) ? w_pair[7:0] : w_pair[15:8];
        end else begin
            ascii = shift ? w_pair[7:0] : w_pair[15:8];
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns a PS/2 scan-code byte stream into make/break key events with ASCII, buffered in a small FIFO.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [7:0] evt_ascii,
    output logic       shift,
    output logic       caps,
    output logic [7:0] press_count,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    ps2_state_e r_state, w_state_nxt;
    logic       w_emit, w_brk, w_ext, w_rpt, w_held_match;
    logic [7:0] w_map, w_ascii;

    logic [7:0] r_held_code;
    logic       r_held_ext, r_held_v;
    logic       r_shift_l, r_shift_r, r_caps, r_overflow;
    logic [7:0] r_press_count;

    ps2_evt_t   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [AW:0]   r_count;
    logic       w_full, w_pop, w_push_ok;
    ps2_evt_t   w_head, w_new;

    // Prefix FSM: E0/F0 bytes only move state; any other byte completes an event.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (code == PS2_PREFIX_EXT)      w_state_nxt = ST_GOT_E0;
                    else if (code == PS2_PREFIX_BRK) w_state_nxt = ST_GOT_F0;
                    else                             w_emit = 1'b1;
                end
                ST_GOT_E0: begin
                    if (code == PS2_PREFIX_BRK)      w_state_nxt = ST_GOT_E0F0;
                    else if (code == PS2_PREFIX_EXT) w_state_nxt = ST_GOT_E0;
                    else begin
                        w_emit = 1'b1; w_ext = 1'b1; w_state_nxt = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    if (code == PS2_PREFIX_BRK)      w_state_nxt = ST_GOT_F0;
                    else if (code == PS2_PREFIX_EXT) w_state_nxt = ST_GOT_E0;
                    else begin
                        w_emit = 1'b1; w_brk = 1'b1; w_state_nxt = ST_IDLE;
                    end
                end
                ST_GOT_E0F0: begin
                    if (code == PS2_PREFIX_EXT)      w_state_nxt = ST_GOT_E0;
                    else if (code == PS2_PREFIX_BRK) w_state_nxt = ST_GOT_F0;
                    else begin
                        w_emit = 1'b1; w_brk = 1'b1; w_ext = 1'b1; w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign w_held_match = r_held_v && (r_held_ext == w_ext) && (r_held_code == code);
    assign w_rpt        = !w_brk && w_held_match;

    ps2_scan2ascii u_scan2ascii (
        .code  (code),
        .shift (shift),
        .caps  (r_caps),
        .ascii (w_map)
    );

    assign w_ascii = w_ext ? 8'h00 : w_map;
    assign w_new   = '{ascii: w_ascii, rpt: w_rpt, brk: w_brk, ext: w_ext, code: code};

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop     = (r_count != '0) && evt_ready;
    assign w_push_ok = w_emit && (!w_full || w_pop);

    // Decoder state, held key, modifiers, press counter and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_held_code   <= 8'h00;
            r_held_ext    <= 1'b0;
            r_held_v      <= 1'b0;
            r_shift_l     <= 1'b0;
            r_shift_r     <= 1'b0;
            r_caps        <= 1'b0;
            r_press_count <= 8'h00;
            r_overflow    <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_emit && !w_brk && !w_rpt) begin
                r_held_code   <= code;
                r_held_ext    <= w_ext;
                r_held_v      <= 1'b1;
                r_press_count <= r_press_count + 8'd1;
            end else if (w_emit && w_brk && w_held_match) begin
                r_held_v <= 1'b0;
            end
            if (w_emit && !w_ext) begin
                if (code == PS2_LSHIFT) r_shift_l <= !w_brk;
                if (code == PS2_RSHIFT) r_shift_r <= !w_brk;
                if (code == PS2_CAPS && !w_brk && !w_rpt) r_caps <= !r_caps;
            end
            if (w_emit && !w_push_ok) r_overflow <= 1'b1;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            if (w_pop)     r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Event storage; contents are don't-care until written, outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_new;
    end

    assign w_head = r_mem[r_rd_ptr];

    // Head presentation: all fields read as zero while the FIFO is empty.
    always_comb begin
        if (r_count != '0) begin
            evt_valid  = 1'b1;
            evt_code   = w_head.code;
            evt_ext    = w_head.ext;
            evt_break  = w_head.brk;
            evt_repeat = w_head.rpt;
            evt_ascii  = w_head.ascii;
        end else begin
            evt_valid  = 1'b0;
            evt_code   = 8'h00;
            evt_ext    = 1'b0;
            evt_break  = 1'b0;
            evt_repeat = 1'b0;
            evt_ascii  = 8'h00;
        end
    end

    assign shift       = r_shift_l | r_shift_r;
    assign caps        = r_caps;
    assign press_count = r_press_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with hand-computed expected events.
module tb_ps2_key_decoder;

    logic       clk, reset, code_valid, evt_valid, evt_ready;
    logic [7:0] code, evt_code, evt_ascii, press_count;
    logic       evt_ext, evt_break, evt_repeat, shift, caps, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_key_decoder #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_break(evt_break), .evt_repeat(evt_repeat),
        .evt_ascii(evt_ascii), .shift(shift), .caps(caps),
        .press_count(press_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the edge that samples the byte.
    task automatic send(input logic [7:0] b);
        code = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0;
    endtask

    function automatic logic [31:0] head();
        return 32'({evt_ascii, evt_repeat, evt_break, evt_ext, evt_code});
    endfunction

    function automatic logic [31:0] ev(input logic [7:0] a, input logic r, input logic b,
                                       input logic e, input logic [7:0] c);
        return 32'({a, r, b, e, c});
    endfunction

    task automatic pop_expect(input string tag, input logic [7:0] c, input logic e,
                              input logic b, input logic r, input logic [7:0] a);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk(tag, head(), ev(a, r, b, e, c));
        evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; code = 8'h00; code_valid = 1'b0; evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_head", head(), 32'd0);
        chk("rst_mods", 32'({shift, caps, overflow}), 32'd0);
        chk("rst_press", 32'(press_count), 32'd0);

        // Plain make/break of 'a'
        send(8'h1C);
        chk("t1_latency", 32'(evt_valid), 32'd1);
        send(8'hF0);
        send(8'h1C);
        pop_expect("t1_make", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61);
        pop_expect("t1_brk",  8'h1C, 1'b0, 1'b1, 1'b0, 8'h61);
        chk("t1_press", 32'(press_count), 32'd1);
        chk("t1_empty", 32'(evt_valid), 32'd0);

        // Shifted letter, then caps lock
        send(8'h12);
        chk("t2_shift_on", 32'(shift), 32'd1);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        chk("t2_shift_off", 32'(shift), 32'd0);
        pop_expect("t2_lsh_make", 8'h12, 1'b0, 1'b0, 1'b0, 8'h00);
        pop_expect("t2_A_make",   8'h1C, 1'b0, 1'b0, 1'b0, 8'h41);
        pop_expect("t2_A_brk",    8'h1C, 1'b0, 1'b1, 1'b0, 8'h41);
        pop_expect("t2_lsh_brk",  8'h12, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("t2_no_ovf", 32'(overflow), 32'd0);
        send(8'h58);
        chk("t2_caps_on", 32'(caps), 32'd1);
        send(8'hF0); send(8'h58); send(8'h1C);
        pop_expect("t2_caps_make", 8'h58, 1'b0, 1'b0, 1'b0, 8'h00);
        pop_expect("t2_caps_brk",  8'h58, 1'b0, 1'b1, 1'b0, 8'h00);
        pop_expect("t2_capsA",     8'h1C, 1'b0, 1'b0, 1'b0, 8'h41);
        chk("t2_caps", 32'(caps), 32'd1);
        chk("t2_press", 32'(press_count), 32'd5);

        // Extended key
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        pop_expect("t3_ext_make", 8'h75, 1'b1, 1'b0, 1'b0, 8'h00);
        pop_expect("t3_ext_brk",  8'h75, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("t3_mods", 32'({shift, caps}), 32'd1);
        chk("t3_press", 32'(press_count), 32'd6);

        // Typematic repeat (caps on, so 'A')
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        pop_expect("t4_make0", 8'h1C, 1'b0, 1'b0, 1'b0, 8'h41);
        pop_expect("t4_rep1",  8'h1C, 1'b0, 1'b0, 1'b1, 8'h41);
        pop_expect("t4_rep2",  8'h1C, 1'b0, 1'b0, 1'b1, 8'h41);
        pop_expect("t4_brk",   8'h1C, 1'b0, 1'b1, 1'b0, 8'h41);
        chk("t4_press", 32'(press_count), 32'd7);

        // Overflow with consumer stalled
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        chk("t5_ovf_before", 32'(overflow), 32'd0);
        send(8'h2C);
        chk("t5_ovf_after", 32'(overflow), 32'd1);
        send(8'h35);
        chk("t5_press", 32'(press_count), 32'd13);
        pop_expect("t5_q", 8'h15, 1'b0, 1'b0, 1'b0, 8'h51);
        pop_expect("t5_w", 8'h1D, 1'b0, 1'b0, 1'b0, 8'h57);
        pop_expect("t5_e", 8'h24, 1'b0, 1'b0, 1'b0, 8'h45);
        pop_expect("t5_r", 8'h2D, 1'b0, 1'b0, 1'b0, 8'h52);
        chk("t5_drained", 32'(evt_valid), 32'd0);

        // Reset mid-sequence discards the pending E0
        send(8'hE0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("t6_cleared", 32'({evt_valid, shift, caps, overflow}), 32'd0);
        chk("t6_press0", 32'(press_count), 32'd0);
        send(8'h74);
        pop_expect("t6_make", 8'h74, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_press1", 32'(press_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
